bshift_word_ctrl: RTL and testbench

Deserializing controller that sequences a bshift_register to pack a serial bit stream into BITS-wide words. Upstream side is a per-bit valid/ready handshake; downstream side is a word valid/ready handshake with backpressure. Sits between serial sources (pixel/sync bit streams) and word-wide VGA consumers such as line buffers and palette lookups.

---
 rtl/bshift_word_ctrl_pkg.sv | 13 +
 rtl/bshift_word_ctrl_register.sv | 33 +++
 rtl/bshift_word_ctrl.sv | 136 +++++++++++++
 tb/tb_bshift_word_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bshift_word_ctrl_pkg.sv
// Shared constants and types for the serial-to-word deserializer.
// State encodings and the drop-counter width.
package bshift_word_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/bshift_word_ctrl_register.sv
// Serial-in, parallel-out shift register used as the word datapath.
// Newest bit enters at [0]; synchronous active-high clear wins over enable.
module bshift_register #(
    parameter int BITS = 5
) (
    input  logic            clk,
    input  logic            i_sclr,
    input  logic            i_en,
    input  logic            i_dat,
    output logic [BITS-1:0] o_data
);

    logic [BITS-1:0] data_q;
    logic [BITS-1:0] data_d;

    // Next shift-register contents: clear, shift in, or hold.
    always_comb begin
        data_d = data_q;
        if (i_sclr) begin
            data_d = '0;
        end else if (i_en) begin
            data_d = {data_q[BITS-2:0], i_dat};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign o_data = data_q;

endmodule

// File: rtl/bshift_word_ctrl.sv
// Packs a per-bit valid/ready stream into BITS-wide words with backpressure.
// Optional macro BSHIFT_DROP_CNT_EN adds a saturating dropped-bit counter.
module bshift_word_ctrl
    import bshift_word_ctrl_pkg::*;
#(
    parameter int BITS  = 5,
    localparam int CNT_W = $clog2(BITS)
) (
    input  logic             clk,
    input  logic             i_sclr_n,
    input  logic             i_sdat,
    input  logic             i_svalid,
    output logic             o_sready,
    input  logic             i_flush,
    output logic [BITS-1:0]  o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_bitcnt,
`ifdef BSHIFT_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] o_drop_cnt,
`endif
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sready;
    logic             acc;

    assign acc = i_svalid & sready;

    // State and bit-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and bit count; flush outranks any accepted data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        state_d = ST_SHIFT;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (acc) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_FULL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_FULL: begin
                    if (i_ready) begin
                        if (acc) begin
                            state_d = ST_SHIFT;
                            cnt_d   = CNT_ONE;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        sready  = ~i_flush & ((state_q != ST_FULL) | i_ready);
        o_valid = (state_q == ST_FULL);
        o_busy  = (state_q != ST_IDLE);
    end

    assign o_sready = sready;
    assign o_bitcnt = cnt_q;

    bshift_register #(
        .BITS (BITS)
    ) u_sreg (
        .clk    (clk),
        .i_sclr (~i_sclr_n),
        .i_en   (acc),
        .i_dat  (i_sdat),
        .o_data (o_data)
    );

`ifdef BSHIFT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    // Count offered-but-refused bits, saturating at all ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_svalid & ~sready & (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bshift_word_ctrl.sv
// Directed bench for bshift_word_ctrl with BITS=5.
// Define BSHIFT_DROP_CNT_EN to also check the drop counter.
module tb_bshift_word_ctrl;

    logic       clk;
    logic       i_sclr_n;
    logic       i_sdat;
    logic       i_svalid;
    logic       o_sready;
    logic       i_flush;
    logic [4:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [2:0] o_bitcnt;
    logic       o_busy;
`ifdef BSHIFT_DROP_CNT_EN
    logic [7:0] o_drop_cnt;
`endif

    int n_checks;
    int n_errors;

    bshift_word_ctrl #(
        .BITS (5)
    ) dut (
        .clk      (clk),
        .i_sclr_n (i_sclr_n),
        .i_sdat   (i_sdat),
        .i_svalid (i_svalid),
        .o_sready (o_sready),
        .i_flush  (i_flush),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_bitcnt (o_bitcnt),
`ifdef BSHIFT_DROP_CNT_EN
        .o_drop_cnt (o_drop_cnt),
`endif
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [4:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            i_svalid = 1'b1;
            i_sdat   = bits[i];
            step();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_sclr_n = 1'b0;
        i_sdat   = 1'b0;
        i_svalid = 1'b0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;
        step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_bitcnt", 32'(o_bitcnt), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_sready", 32'(o_sready), 32'd1);

        // Basic word 1,0,1,1,1
        i_sclr_n = 1'b1;
        send_bits(5'b10, 2);
        check("mid_bitcnt", 32'(o_bitcnt), 32'd2);
        check("mid_busy", 32'(o_busy), 32'd1);
        check("mid_valid", 32'(o_valid), 32'd0);
        send_bits(5'b111, 3);
        check("w1_valid", 32'(o_valid), 32'd1);
        check("w1_data", 32'(o_data), 32'h17);
        check("w1_bitcnt", 32'(o_bitcnt), 32'd0);
        check("w1_sready", 32'(o_sready), 32'd0);

        // Backpressure for three clocks
        send_bits(5'b000, 3);
        check("bp_data", 32'(o_data), 32'h17);
        check("bp_valid", 32'(o_valid), 32'd1);
        check("bp_sready", 32'(o_sready), 32'd0);
`ifdef BSHIFT_DROP_CNT_EN
        check("bp_drop", 32'(o_drop_cnt), 32'd3);
`endif

        // Back-to-back: consume and accept bit 0 in the same cycle
        i_ready = 1'b1;
        send_bits(5'b0, 1);
        check("b2b_valid", 32'(o_valid), 32'd0);
        check("b2b_bitcnt", 32'(o_bitcnt), 32'd1);
        check("b2b_busy", 32'(o_busy), 32'd1);
        i_ready = 1'b0;
        send_bits(5'b1110, 4);
        check("w2_data", 32'(o_data), 32'h0e);
        check("w2_valid", 32'(o_valid), 32'd1);

        // Consume with no new bit -> IDLE
        i_ready  = 1'b1;
        i_svalid = 1'b0;
        step();
        check("cons_valid", 32'(o_valid), 32'd0);
        check("cons_busy", 32'(o_busy), 32'd0);
        i_ready = 1'b0;

        // Flush a partial word
        send_bits(5'b111, 3);
        check("pre_fl_cnt", 32'(o_bitcnt), 32'd3);
        i_flush  = 1'b1;
        i_svalid = 1'b1;
        i_sdat   = 1'b0;
        #1;
        check("fl_sready", 32'(o_sready), 32'd0);
        step();
        i_flush = 1'b0;
        check("fl_bitcnt", 32'(o_bitcnt), 32'd0);
        check("fl_busy", 32'(o_busy), 32'd0);
        check("fl_valid", 32'(o_valid), 32'd0);
        check("fl_data", 32'(o_data), 32'h17);
`ifdef BSHIFT_DROP_CNT_EN
        check("fl_drop", 32'(o_drop_cnt), 32'd4);
`endif
        send_bits(5'b00001, 5);
        check("w3_data", 32'(o_data), 32'h01);
        check("w3_valid", 32'(o_valid), 32'd1);

        // Reset mid-word
        i_ready  = 1'b1;
        i_svalid = 1'b0;
        step();
        i_ready = 1'b0;
        send_bits(5'b11, 2);
        check("pre_rst_cnt", 32'(o_bitcnt), 32'd2);
        i_sclr_n = 1'b0;
        i_svalid = 1'b1;
        i_sdat   = 1'b1;
        step();
        i_sclr_n = 1'b1;
        check("mrst_data", 32'(o_data), 32'd0);
        check("mrst_bitcnt", 32'(o_bitcnt), 32'd0);
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_busy", 32'(o_busy), 32'd0);
`ifdef BSHIFT_DROP_CNT_EN
        check("mrst_drop", 32'(o_drop_cnt), 32'd0);
`endif
        send_bits(5'b11001, 5);
        check("w4_data", 32'(o_data), 32'h19);
        check("w4_valid", 32'(o_valid), 32'd1);

`ifdef BSHIFT_DROP_CNT_EN
        // Saturation while held FULL
        for (int i = 0; i < 260; i++) begin
            i_svalid = 1'b1;
            step();
        end
        check("sat_drop", 32'(o_drop_cnt), 32'hff);
        check("sat_data", 32'(o_data), 32'h19);
`endif

        // Flush discards a held word even with i_ready=1
        i_flush  = 1'b1;
        i_ready  = 1'b1;
        i_svalid = 1'b1;
        step();
        i_flush  = 1'b0;
        i_ready  = 1'b0;
        i_svalid = 1'b0;
        check("flf_valid", 32'(o_valid), 32'd0);
        check("flf_busy", 32'(o_busy), 32'd0);
        check("flf_data", 32'(o_data), 32'h19);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
